// File: rtl/gps_tb_pkg.sv
// Shared constants for the GPS time base: register map (word offsets on
// wb_adr_i[4:2]), STATUS bit positions and hardware-reset default periods.
package gps_tb_pkg;

  typedef enum logic [2:0] {
    REG_PROG_TIC   = 3'd0,
    REG_PROG_ACCUM = 3'd1,
    REG_SW_RESET   = 3'd2,
    REG_STATUS     = 3'd3,
    REG_NEW_DATA   = 3'd4,
    REG_INT_EN     = 3'd5
  } reg_sel_e;

  localparam int STAT_TIC_BIT = 0;
  localparam int STAT_ACC_BIT = 1;

  // Period minus one: 100 ms TIC and 0.5 ms accum at 48 MHz.
  localparam logic [23:0] TIC_DEFAULT_P = 24'h493DFF;
  localparam logic [15:0] ACC_DEFAULT_P = 16'h5DBF;

endpackage

// File: rtl/gps_time_base_mc_if.sv
// Wishbone slave bus of the GPS time base.
//   slave  : adr/dat/sel/stb/cyc/we in, dat_o/ack out
//   master : mirror image for the bus owner
interface gps_time_base_mc_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/gps_time_base_mc_period_strobe.sv
// Programmable period strobe: a down-counter that pulses strobe_o for one
// cycle when it reaches zero and reloads period_i (period = period_i+1).
//   clk, rst_n     : clock, async active-low reset (count -> DEFAULT)
//   period_i       : reload value, sampled only at reload time
//   soft_reload_i  : force an immediate reload; suppresses the strobe
//   strobe_o       : one-cycle pulse at terminal count
module gps_period_strobe #(
  parameter int           W       = 24,
  parameter logic [W-1:0] DEFAULT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] period_i,
  input  logic         soft_reload_i,
  output logic         strobe_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    strobe_o = 1'b0;
    cnt_d    = cnt_q - W'(1);
    if (soft_reload_i) begin
      cnt_d = period_i;
    end else if (cnt_q == '0) begin
      strobe_o = 1'b1;
      cnt_d    = period_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= DEFAULT;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gps_time_base_mc.sv
// GPS time base: TIC and accumulation period strobes, event STATUS and
// per-channel NEW_DATA flags, accumulation interrupt, Wishbone registers.
//   clk, hw_rstn  : clock, async active-low reset
//   wb            : Wishbone slave (registered single-cycle ack)
//   ch_dump       : per-channel dump pulses, latched into NEW_DATA
//   tic_enable    : TIC period strobe
//   accum_enable  : accumulation period strobe
//   accum_int     : STATUS accum flag gated by INT_EN
module gps_time_base_mc
  import gps_tb_pkg::*;
#(
  parameter int               NUM_CH      = 12,
  parameter int               TIC_W       = 24,
  parameter int               ACC_W       = 16,
  parameter logic [TIC_W-1:0] TIC_DEFAULT = TIC_W'(TIC_DEFAULT_P),
  parameter logic [ACC_W-1:0] ACC_DEFAULT = ACC_W'(ACC_DEFAULT_P)
) (
  input  logic              clk,
  input  logic              hw_rstn,
  gps_time_base_mc_if.slave wb,
  input  logic [NUM_CH-1:0] ch_dump,
  output logic              tic_enable,
  output logic              accum_enable,
  output logic              accum_int
);

  logic              ack_q, we_q, int_en_q;
  logic [2:0]        adr_q;
  logic [31:0]       dat_q, rdata;
  logic [TIC_W-1:0]  prog_tic_q;
  logic [ACC_W-1:0]  prog_acc_q;
  logic [1:0]        status_q, status_d;
  logic [NUM_CH-1:0] new_q, new_d;
  logic              req, rd, wr, sw_rst, status_clr, new_clr;
  logic              unused_bits;

  // The access is captured at request time and executed in the ack cycle,
  // so side effects happen exactly once per transfer.
  assign req        = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign wr         = ack_q & we_q;
  assign rd         = ack_q & ~we_q;
  assign sw_rst     = wr && (adr_q == REG_SW_RESET);
  assign status_clr = (rd && (adr_q == REG_STATUS)) || sw_rst;
  assign new_clr    = (rd && (adr_q == REG_NEW_DATA)) || sw_rst;

  assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:5], wb.wb_adr_i[1:0], dat_q};

  always_ff @(posedge clk or negedge hw_rstn) begin
    if (!hw_rstn) begin
      ack_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      if (req) begin
        we_q  <= wb.wb_we_i;
        adr_q <= wb.wb_adr_i[4:2];
        dat_q <= wb.wb_dat_i;
      end
    end
  end

  always_ff @(posedge clk or negedge hw_rstn) begin
    if (!hw_rstn) begin
      prog_tic_q <= TIC_DEFAULT;
      prog_acc_q <= ACC_DEFAULT;
      int_en_q   <= 1'b1;
    end else if (wr) begin
      case (adr_q)
        REG_PROG_TIC:   prog_tic_q <= dat_q[TIC_W-1:0];
        REG_PROG_ACCUM: prog_acc_q <= dat_q[ACC_W-1:0];
        REG_INT_EN:     int_en_q   <= dat_q[0];
        default: ;
      endcase
    end
  end

  // Clear first, then OR in this cycle's events so a coincident event wins.
  always_comb begin
    status_d               = status_clr ? '0 : status_q;
    status_d[STAT_TIC_BIT] = status_d[STAT_TIC_BIT] | tic_enable;
    status_d[STAT_ACC_BIT] = status_d[STAT_ACC_BIT] | accum_enable;
    new_d                  = (new_clr ? '0 : new_q) | ch_dump;
  end

  always_ff @(posedge clk or negedge hw_rstn) begin
    if (!hw_rstn) begin
      status_q <= '0;
      new_q    <= '0;
    end else begin
      status_q <= status_d;
      new_q    <= new_d;
    end
  end

  // Read data reflects pre-clear register contents during the ack cycle.
  always_comb begin
    rdata = '0;
    case (adr_q)
      REG_PROG_TIC:   rdata = 32'(prog_tic_q);
      REG_PROG_ACCUM: rdata = 32'(prog_acc_q);
      REG_STATUS:     rdata = 32'(status_q);
      REG_NEW_DATA:   rdata = 32'(new_q);
      REG_INT_EN:     rdata = {31'd0, int_en_q};
      default:        rdata = '0;
    endcase
  end

  assign wb.wb_dat_o = rd ? rdata : '0;
  assign wb.wb_ack_o = ack_q;
  assign accum_int   = status_q[STAT_ACC_BIT] & int_en_q;

  gps_period_strobe #(.W(TIC_W), .DEFAULT(TIC_DEFAULT)) u_tic (
    .clk          (clk),
    .rst_n        (hw_rstn),
    .period_i     (prog_tic_q),
    .soft_reload_i(sw_rst),
    .strobe_o     (tic_enable)
  );

  gps_period_strobe #(.W(ACC_W), .DEFAULT(ACC_DEFAULT)) u_acc (
    .clk          (clk),
    .rst_n        (hw_rstn),
    .period_i     (prog_acc_q),
    .soft_reload_i(sw_rst),
    .strobe_o     (accum_enable)
  );

endmodule

// File: tb/tb_gps_time_base_mc.sv
// Self-checking bench for gps_time_base_mc: register vector table, directed
// multi-cycle sequences and randomized traffic against a simple model.
module tb_gps_time_base_mc;
  import gps_tb_pkg::*;

  localparam int NCH = 12;

  logic           clk = 1'b0;
  logic           hw_rstn = 1'b0;
  logic [NCH-1:0] ch_dump = '0;
  logic           tic_enable, accum_enable, accum_int;

  gps_time_base_mc_if wb();

  gps_time_base_mc #(
    .NUM_CH(NCH), .TIC_W(24), .ACC_W(16),
    .TIC_DEFAULT(24'h493DFF), .ACC_DEFAULT(16'h5DBF)
  ) dut (
    .clk(clk), .hw_rstn(hw_rstn), .wb(wb), .ch_dump(ch_dump),
    .tic_enable(tic_enable), .accum_enable(accum_enable), .accum_int(accum_int)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  int tic_q[$];
  int acc_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Strobe log: cycle index of every observed pulse.
  always @(negedge clk) begin
    if (tic_enable === 1'b1)   tic_q.push_back(cyc_cnt);
    if (accum_enable === 1'b1) acc_q.push_back(cyc_cnt);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // One Wishbone transfer. dump_ack is driven on ch_dump during the ack cycle.
  task automatic xfer(input bit we, input logic [2:0] a, input logic [31:0] wd,
                      input logic [NCH-1:0] dump_ack, output logic [31:0] rdat,
                      output int ack_cyc);
    logic [31:0] r;
    bit got;
    r = $urandom();
    @(negedge clk);
    wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = {r[31:5], a, r[1:0]};
    wb.wb_dat_i = wd;
    wb.wb_sel_i = r[3:0];
    got = 1'b0; rdat = '0; ack_cyc = -1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (wb.wb_ack_o === 1'b1) begin
        got = 1'b1; rdat = wb.wb_dat_o; ack_cyc = cyc_cnt;
      end
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    @(negedge clk);
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
    ch_dump = dump_ack;
    @(negedge clk);
    ch_dump = '0;
    check("ack_single", 32'(wb.wb_ack_o), 32'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] rd_unused; int c;
    xfer(1'b1, a, d, '0, rd_unused, c);
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] v; int c;
    xfer(1'b0, a, 32'd0, '0, v, c);
    check(nm, v, exp);
  endtask

  function automatic int first_after(input bit acc, input int a, input int k);
    int n = 0;
    int q[$];
    if (acc) q = acc_q; else q = tic_q;
    foreach (q[i]) begin
      if (q[i] > a) begin
        n++;
        if (n == k) return q[i];
      end
    end
    return -1;
  endfunction

  // Wait (bounded) for the k-th strobe after cycle a; -1 on timeout.
  task automatic wait_evt(input bit acc, input int a, input int k, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget && t < 0; i++) begin
      @(negedge clk); #1;
      t = first_after(acc, a, k);
    end
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  function automatic vec_t mk(input bit we, input logic [2:0] a, input logic [31:0] d,
                              input logic [31:0] exp, input string nm);
    vec_t v;
    v.we = we; v.a = a; v.d = d; v.exp = exp; v.nm = nm;
    return v;
  endfunction

  initial begin
    vec_t vt[$];
    logic [31:0] v, r;
    logic [NCH-1:0] m, da;
    int t, a, a2, base, p;
    bit bad;

    vt.push_back(mk(0, 3'd3, 0, 32'h0,        "tbl_status0"));
    vt.push_back(mk(0, 3'd0, 0, 32'h00493DFF, "tbl_prog_tic"));
    vt.push_back(mk(0, 3'd1, 0, 32'h0000FFFF, "tbl_prog_acc"));
    vt.push_back(mk(0, 3'd5, 0, 32'h1,        "tbl_int_en"));
    vt.push_back(mk(0, 3'd4, 0, 32'h0,        "tbl_new_data0"));
    vt.push_back(mk(0, 3'd2, 0, 32'h0,        "tbl_swrst_rd"));
    vt.push_back(mk(0, 3'd6, 0, 32'h0,        "tbl_unmap6"));
    vt.push_back(mk(0, 3'd7, 0, 32'h0,        "tbl_unmap7"));
    vt.push_back(mk(1, 3'd6, 32'hDEADBEEF, 0, ""));
    vt.push_back(mk(0, 3'd6, 0, 32'h0,        "tbl_unmap6_wr"));
    vt.push_back(mk(1, 3'd0, 32'hFFFFFFFF, 0, ""));
    vt.push_back(mk(0, 3'd0, 0, 32'h00FFFFFF, "tbl_tic_trunc"));
    vt.push_back(mk(1, 3'd1, 32'h00012345, 0, ""));
    vt.push_back(mk(0, 3'd1, 0, 32'h00002345, "tbl_acc_trunc"));
    vt.push_back(mk(1, 3'd5, 32'hFFFFFFFE, 0, ""));
    vt.push_back(mk(0, 3'd5, 0, 32'h0,        "tbl_int_en0"));
    vt.push_back(mk(1, 3'd5, 32'h00000003, 0, ""));
    vt.push_back(mk(0, 3'd5, 0, 32'h1,        "tbl_int_en1"));
    vt.push_back(mk(1, 3'd7, 32'hFFFFFFFF, 0, ""));
    vt.push_back(mk(0, 3'd0, 0, 32'h00FFFFFF, "tbl_unmap7_wr"));

    wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0;
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack",       32'(wb.wb_ack_o),  32'd0);
    check("rst_dat",       wb.wb_dat_o,       32'd0);
    check("rst_tic",       32'(tic_enable),   32'd0);
    check("rst_accum",     32'(accum_enable), 32'd0);
    check("rst_accum_int", 32'(accum_int),    32'd0);
    base = cyc_cnt;
    hw_rstn = 1'b1;

    // Accum period: default first, then PROG_ACCUM=3 from the next reload
    wr(REG_PROG_ACCUM, 32'd3);
    wait_evt(1'b1, 0, 1, 30000, t);
    check("acc_default_first", 32'(t - base), 32'd23999);
    a = t;
    for (int k = 1; k <= 3; k++) begin
      wait_evt(1'b1, a, k, 50, t);
      check("acc_period4", 32'(t - a), 32'(4 * k));
    end
    wr(REG_PROG_ACCUM, 32'h0000FFFF);
    repeat (12) @(negedge clk);
    rd_chk("status_acc",  REG_STATUS, 32'h2);
    rd_chk("status_clr",  REG_STATUS, 32'h0);

    // Register vector table
    foreach (vt[i]) begin
      if (vt[i].we) wr(vt[i].a, vt[i].d);
      else          rd_chk(vt[i].nm, vt[i].a, vt[i].exp);
    end

    // NEW_DATA with a dump coinciding with the clearing read
    @(negedge clk); ch_dump = 12'h005;
    @(negedge clk); ch_dump = '0;
    xfer(1'b0, REG_NEW_DATA, 0, 12'h002, v, t);
    check("nd_read1", v, 32'h005);
    rd_chk("nd_read2", REG_NEW_DATA, 32'h002);

    // Interrupt masking
    wr(REG_INT_EN, 32'd0);
    wr(REG_PROG_ACCUM, 32'd20);
    xfer(1'b1, REG_SW_RESET, 32'hFFFFFFFF, '0, v, a);
    wr(REG_PROG_ACCUM, 32'h0000FFFF);
    wait_evt(1'b1, a, 1, 100, t);
    check("swrst_acc_first", 32'(t - a), 32'd21);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (accum_int !== 1'b0) bad = 1'b1;
    end
    check("int_masked", 32'(bad), 32'd0);
    wr(REG_INT_EN, 32'd1);
    check("int_unmasked", 32'(accum_int), 32'd1);
    rd_chk("int_status", REG_STATUS, 32'h2);
    check("int_cleared", 32'(accum_int), 32'd0);

    // SW_RESET: flags cleared, TIC restarts from PROG_TIC
    wr(REG_PROG_TIC, 32'd9);
    xfer(1'b1, REG_SW_RESET, 32'd0, '0, v, a);
    wait_evt(1'b0, a, 1, 50, t);
    check("tic_first_a", 32'(t - a), 32'd10);
    @(negedge clk); ch_dump = 12'hA50;
    @(negedge clk); ch_dump = '0;
    xfer(1'b1, REG_SW_RESET, 32'h12345678, '0, v, a2);
    rd_chk("swrst_status", REG_STATUS,   32'h0);
    rd_chk("swrst_newdata", REG_NEW_DATA, 32'h0);
    wait_evt(1'b0, a2, 1, 50, t);
    check("tic_first_b", 32'(t - a2), 32'd10);
    wait_evt(1'b0, a2, 2, 50, t);
    check("tic_second_b", 32'(t - a2), 32'd20);

    // Hardware reset in the middle of a read
    @(negedge clk);
    wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = {27'd0, REG_PROG_TIC, 2'b00};
    @(posedge clk); #1;
    check("mid_ack_pre", 32'(wb.wb_ack_o), 32'd1);
    #2 hw_rstn = 1'b0;
    #1;
    check("mid_ack_drop", 32'(wb.wb_ack_o), 32'd0);
    check("mid_dat_drop", wb.wb_dat_o, 32'd0);
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0;
    @(negedge clk);
    @(negedge clk); hw_rstn = 1'b1;
    rd_chk("hrst_prog_tic", REG_PROG_TIC,   32'h00493DFF);
    rd_chk("hrst_prog_acc", REG_PROG_ACCUM, 32'h00005DBF);
    rd_chk("hrst_int_en",   REG_INT_EN,     32'h1);
    rd_chk("hrst_status",   REG_STATUS,     32'h0);

    // Random dumps against a sticky-OR model
    m = '0;
    for (int it = 0; it < 15; it++) begin
      int n;
      n = $urandom_range(0, 4);
      for (int j = 0; j < n; j++) begin
        @(negedge clk);
        r = $urandom();
        ch_dump = r[NCH-1:0];
        m = m | r[NCH-1:0];
      end
      @(negedge clk); ch_dump = '0;
      r = $urandom();
      da = r[31] ? r[NCH-1:0] : '0;
      xfer(1'b0, REG_NEW_DATA, 0, da, v, t);
      check("rnd_newdata", v, 32'(m));
      m = da;
    end

    // Random register round trips (width truncation)
    for (int it = 0; it < 6; it++) begin
      r = $urandom();
      wr(REG_PROG_TIC, r);
      rd_chk("rnd_tic", REG_PROG_TIC, r & 32'h00FFFFFF);
      r = $urandom();
      wr(REG_PROG_ACCUM, r);
      rd_chk("rnd_acc", REG_PROG_ACCUM, r & 32'h0000FFFF);
      r = $urandom();
      wr(REG_INT_EN, r);
      rd_chk("rnd_int_en", REG_INT_EN, r & 32'h1);
    end

    // Random accum periods: strobes at A + k*(P+1) after SW_RESET
    for (int it = 0; it < 4; it++) begin
      p = $urandom_range(1, 12);
      wr(REG_PROG_ACCUM, 32'(p));
      xfer(1'b1, REG_SW_RESET, $urandom(), '0, v, a);
      for (int k = 1; k <= 3; k++) begin
        wait_evt(1'b1, a, k, 200, t);
        check("rnd_acc_period", 32'(t - a), 32'(k * (p + 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gps_time_base_mc.md
GPS_TIME_BASE_MC -- requirements
Module: gps_time_base_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 12, number of correlator channels (1..32).
REQ-002 SHALL have parameter TIC_W, default 24, width of the TIC period counter.
REQ-003 SHALL have parameter ACC_W, default 16, width of the accumulation-interrupt period counter.
REQ-004 SHALL have parameter TIC_DEFAULT, default 24'h493DFF, TIC period minus one after hardware reset (100 ms at 48 MHz).
REQ-005 SHALL have parameter ACC_DEFAULT, default 16'h5DBF, accum period minus one after hardware reset (0.5 ms at 48 MHz).
REQ-006 SHALL have port clk, input, 1: the single system clock; all logic rising-edge.
REQ-007 SHALL have port hw_rstn, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have ports wb_adr_i (input, 32), wb_dat_i (input, 32), wb_dat_o (output, 32), wb_sel_i (input, 4), wb_stb_i, wb_cyc_i, wb_we_i (inputs, 1), wb_ack_o (output, 1): Wishbone slave.
REQ-009 SHALL have port ch_dump, input, NUM_CH: per-channel one-cycle dump pulse from the correlators.
REQ-010 SHALL have ports tic_enable and accum_enable, outputs, 1: one-cycle period strobes to the channels.
REQ-011 SHALL have port accum_int, output, 1: level interrupt to the CPU.

Function
REQ-012 SHALL decode wb_adr_i[4:2] only: 0 PROG_TIC (rw), 1 PROG_ACCUM (rw), 2 SW_RESET (wo), 3 STATUS (ro, read-clear), 4 NEW_DATA (ro, read-clear), 5 INT_EN (rw, bit0); unmapped reads return 0; unmapped writes are ignored.
REQ-013 SHALL assert wb_ack_o registered, one cycle after wb_stb_i&wb_cyc_i while wb_ack_o is low, for exactly one cycle; reads present data in the ack cycle; writes and read side effects take effect in the ack cycle only.
REQ-014 SHALL ignore wb_sel_i; all writes are full-word, truncated to the register width.
REQ-015 SHALL down-count a TIC counter; at 0, pulse tic_enable for one cycle and reload PROG_TIC, giving a period of PROG_TIC+1 clocks.
REQ-016 SHALL handle the accum counter identically with PROG_ACCUM and accum_enable.
REQ-017 SHALL make a PROG_TIC or PROG_ACCUM write affect only the next reload; the running count is not disturbed.
REQ-018 SHALL set STATUS bit0 on tic_enable and bit1 on accum_enable; a STATUS read returns the pre-clear value and clears both bits; a set coinciding with the clearing read leaves that bit set.
REQ-019 SHALL set NEW_DATA bit i on ch_dump[i]; a read returns the pre-clear value zero-extended to 32 bits and clears all bits; a dump coinciding with the read leaves that bit set.
REQ-020 SHALL drive accum_int = STATUS bit1 AND INT_EN bit0.
REQ-021 SHALL, on any SW_RESET write (data ignored) in the ack cycle, load both counters from the PROG registers and clear STATUS and NEW_DATA; PROG and INT_EN are kept; no strobe is emitted in that cycle.
REQ-022 SHALL make strobes and dump flags resume normally after SW_RESET, with the first tic_enable exactly PROG_TIC+1 clocks after the reset cycle.

Reset
REQ-023 SHALL, while hw_rstn is low, set PROG_TIC=TIC_DEFAULT, PROG_ACCUM=ACC_DEFAULT, counters to their defaults, STATUS=0, NEW_DATA=0, INT_EN=1, and wb_ack_o, wb_dat_o, tic_enable, accum_enable, accum_int=0.
REQ-024 SHALL, on reset assertion mid-transaction, drop wb_ack_o immediately and discard the pending access.

Structure
REQ-025 SHALL take register offsets, STATUS bit positions and default periods from the shared package gps_tb_pkg.
REQ-026 SHALL instantiate one sub-module gps_period_strobe, parametrised by width, twice (TIC and accum): counter, reload, strobe and soft-reload input.

Verification
REQ-027 SHALL check: reset released, PROG_ACCUM=3 written -> accum_enable pulses every 4 clocks; STATUS read -> 32'h2, then 32'h0.
REQ-028 SHALL check: NUM_CH=12, ch_dump=12'h005 -> NEW_DATA read returns 32'h005; ch_dump[1] in the read's ack cycle -> returns 32'h005, next read 32'h002.
REQ-029 SHALL check: INT_EN=0, accum event -> accum_int stays 0 with STATUS bit1=1; INT_EN=1 -> accum_int=1; STATUS read -> accum_int=0.
REQ-030 SHALL check: PROG_TIC=9, SW_RESET write -> STATUS=0, NEW_DATA=0, and the first tic_enable exactly 10 clocks later.
REQ-031 SHALL check: hw_rstn low during a read -> wb_ack_o=0 at once; after release, PROG_TIC reads 32'h00493DFF.
